// File: rtl/bram_access_pkg.sv
// Shared definitions for the BRAM access unit: request size encodings,
// FSM state type and the alignment check used at accept time.
package bram_access_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_DATA = 3'd1,
    ST_MERGE     = 3'd2,
    ST_WRITE     = 3'd3,
    ST_ERR       = 3'd4
  } state_t;

  // Request cannot be served: illegal size or address not naturally aligned.
  function automatic logic req_bad(input logic [1:0] size, input logic [1:0] off);
    req_bad = (size == SIZE_ILL) ||
              (size == SIZE_HALF && off[0]) ||
              (size == SIZE_WORD && off != 2'b00);
  endfunction

endpackage

// File: rtl/bram_lane_align.sv
// Combinational byte-lane steering between BRAM words and core data.
//   word       : BRAM word (read data)
//   wdata      : right-aligned store data
//   off        : byte offset within the word
//   size       : SIZE_BYTE / SIZE_HALF / SIZE_WORD
//   is_unsigned: zero-extend loads when set, sign-extend otherwise
//   ext        : load result extracted from word
//   merged     : word with wdata inserted at the addressed lane(s)
module bram_lane_align
  import bram_access_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [1:0]            off,
  input  logic [1:0]            size,
  input  logic                  is_unsigned,
  output logic [DATA_WIDTH-1:0] ext,
  output logic [DATA_WIDTH-1:0] merged
);

  localparam int NUM_LANES = DATA_WIDTH / 8;

  logic [NUM_LANES-1:0][7:0] lane_in;
  logic [NUM_LANES-1:0][7:0] lane_wd;
  logic [NUM_LANES-1:0][7:0] lane_out;

  assign lane_in = word;
  assign lane_wd = wdata;
  assign merged  = lane_out;

  // Each output lane picks either the old BRAM byte or the matching store byte.
  // For halves, store byte 0/1 lands in the low/high lane of the selected half.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam logic [1:0] LANE = 2'(i);
    logic hit_b, hit_h, hit_w;
    assign hit_b = (size == SIZE_BYTE) && (off == LANE);
    assign hit_h = (size == SIZE_HALF) && (off[1] == LANE[1]);
    assign hit_w = (size == SIZE_WORD);
    assign lane_out[i] = hit_b ? lane_wd[0] :
                         hit_h ? lane_wd[LANE[0]] :
                         hit_w ? lane_wd[i] : lane_in[i];
  end

  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  assign sel_b = lane_in[off];
  assign sel_h = off[1] ? {lane_in[3], lane_in[2]} : {lane_in[1], lane_in[0]};

  always_comb begin
    ext = word;
    case (size)
      SIZE_BYTE: ext = {{(DATA_WIDTH-8){~is_unsigned & sel_b[7]}}, sel_b};
      SIZE_HALF: ext = {{(DATA_WIDTH-16){~is_unsigned & sel_h[15]}}, sel_h};
      default:   ext = word;
    endcase
  end

endmodule

// File: rtl/bram_access_unit.sv
// Initiator-side BRAM port: converts byte/half/word loads and stores into
// BRAM word accesses. Sub-word stores are read-modify-write.
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   req_*                 : request handshake (valid/ready), write, size,
//                           unsigned, byte address, right-aligned store data
//   resp_valid/error/rdata: one-cycle completion pulse with status and load data
//   bram_*                : one BRAM instance (read data valid the cycle after readEnable)
module bram_access_unit
  import bram_access_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH+1:0] req_address,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic                  resp_error,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  bram_readEnable,
  output logic [ADDR_WIDTH-1:0] bram_readAddress,
  input  logic [DATA_WIDTH-1:0] bram_readData,
  output logic                  bram_writeEnable,
  output logic [ADDR_WIDTH-1:0] bram_writeAddress,
  output logic [DATA_WIDTH-1:0] bram_writeData
);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [DATA_WIDTH-1:0] data_q;   // store data, replaced by the merged word in MERGE

  logic [DATA_WIDTH-1:0] ext_word;
  logic [DATA_WIDTH-1:0] merged_word;

  bram_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .word        (bram_readData),
    .wdata       (data_q),
    .off         (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .ext         (ext_word),
    .merged      (merged_word)
  );

  // Reset gates every output so a reset landing on any state produces
  // no handshake, no response and no BRAM access in that cycle.
  always_comb begin
    state_nxt        = state;
    req_ready        = 1'b0;
    resp_valid       = 1'b0;
    resp_error       = 1'b0;
    resp_rdata       = '0;
    bram_readEnable  = 1'b0;
    bram_writeEnable = 1'b0;
    if (!reset) begin
      case (state)
        ST_IDLE: begin
          req_ready = 1'b1;
          if (req_valid) begin
            if (req_bad(req_size, req_address[1:0])) begin
              state_nxt = ST_ERR;
            end else if (!req_write) begin
              bram_readEnable = 1'b1;
              state_nxt       = ST_LOAD_DATA;
            end else if (req_size == SIZE_WORD) begin
              state_nxt = ST_WRITE;
            end else begin
              bram_readEnable = 1'b1;
              state_nxt       = ST_MERGE;
            end
          end
        end
        ST_LOAD_DATA: begin
          resp_valid = 1'b1;
          resp_rdata = ext_word;
          state_nxt  = ST_IDLE;
        end
        ST_MERGE: state_nxt = ST_WRITE;
        ST_WRITE: begin
          bram_writeEnable = 1'b1;
          resp_valid       = 1'b1;
          state_nxt        = ST_IDLE;
        end
        ST_ERR: begin
          resp_valid = 1'b1;
          resp_error = 1'b1;
          state_nxt  = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Read address follows the request only while it can be accepted; otherwise
  // the latched address is shown (readEnable is low then, so it is inert).
  assign bram_readAddress  = (state == ST_IDLE) ? req_address[ADDR_WIDTH+1:2]
                                                : addr_q[ADDR_WIDTH+1:2];
  assign bram_writeAddress = addr_q[ADDR_WIDTH+1:2];
  assign bram_writeData    = data_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= ST_IDLE;
      addr_q <= '0;
      size_q <= SIZE_BYTE;
      uns_q  <= 1'b0;
      data_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && req_valid) begin
        addr_q <= req_address;
        size_q <= req_size;
        uns_q  <= req_unsigned;
        data_q <= req_wdata;
      end else if (state == ST_MERGE) begin
        data_q <= merged_word;
      end
    end
  end

endmodule
